// File: rtl/sub_4_serial.sv
// rtl/sub_4_serial.sv - bit-serial WIDTH-bit subtractor (d = x - y - b_in) with start/done handshake
// Optional macro SUB_4_SAT_EN: clamp d_o to 0 when the final borrow is set.
module sub_4_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] d_o,
    output logic             b_o,
    output logic             v_o
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             b_q, b_d;
    logic             v_q, v_d;

    logic             diff;
    logic             brw_nxt;
    logic [WIDTH-1:0] result;

    // Single full-subtractor cell operating on the LSBs of the operand shifters.
    always_comb begin
        diff    = x_q[0] ^ y_q[0] ^ brw_q;
        brw_nxt = (~x_q[0] & y_q[0]) | (~(x_q[0] ^ y_q[0]) & brw_q);
        result  = {diff, r_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        d_d     = d_q;
        b_d     = b_q;
        v_d     = v_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    x_d     = x_i;
                    y_d     = y_i;
                    brw_d   = b_i;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                x_d   = x_q >> 1;
                y_d   = y_q >> 1;
                brw_d = brw_nxt;
                r_d   = result;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
`ifdef SUB_4_SAT_EN
                    d_d = brw_nxt ? '0 : result;
`else
                    d_d = result;
`endif
                    b_d = brw_nxt;
                    // x_q[0]/y_q[0] hold the operand MSBs on this final edge.
                    v_d = (x_q[0] ^ y_q[0]) & (x_q[0] ^ diff);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_SHIFT);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
            b_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            d_q     <= d_d;
            b_q     <= b_d;
            v_q     <= v_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign d_o    = d_q;
    assign b_o    = b_q;
    assign v_o    = v_q;

endmodule

// File: tb/tb_sub_4_serial.sv
// tb/tb_sub_4_serial.sv - self-checking bench for sub_4_serial against an arithmetic reference model
module tb_sub_4_serial;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       start_i = 1'b0;
    logic [3:0] x_i = '0;
    logic [3:0] y_i = '0;
    logic       b_i = 1'b0;
    logic       busy_o, done_o, b_o, v_o;
    logic [3:0] d_o;

    int checks = 0;
    int failures = 0;

    sub_4_serial #(.WIDTH(4)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .start_i(start_i),
        .x_i    (x_i),
        .y_i    (y_i),
        .b_i    (b_i),
        .busy_o (busy_o),
        .done_o (done_o),
        .d_o    (d_o),
        .b_o    (b_o),
        .v_o    (v_o)
    );

    always #5 clk_i = ~clk_i;

    // Returns {v, b, d[3:0]} from plain integer arithmetic.
    function automatic logic [5:0] ref_sub(input int x, input int y, input int b);
        int u, sx, sy, s;
        logic [3:0] dd;
        logic bo, vo;
        u  = x - y - b;
        sx = (x >= 8) ? x - 16 : x;
        sy = (y >= 8) ? y - 16 : y;
        s  = sx - sy - b;
        dd = u[3:0];
        bo = (u < 0);
        vo = (s < -8) || (s > 7);
`ifdef SUB_4_SAT_EN
        if (bo) dd = 4'd0;
`endif
        return {vo, bo, dd};
    endfunction

    task automatic do_op(input logic [3:0] x, input logic [3:0] y, input logic b,
                         output logic [5:0] res, output int lat,
                         output logic busy_ok, output logic stable_ok);
        logic [3:0] prev;
        @(negedge clk_i);
        start_i = 1'b1; x_i = x; y_i = y; b_i = b;
        prev = d_o;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0; x_i = $urandom; y_i = $urandom; b_i = $urandom;
        lat = 0; busy_ok = 1'b1; stable_ok = 1'b1;
        while (done_o !== 1'b1 && lat < 20) begin
            if (busy_o !== 1'b1) busy_ok = 1'b0;
            if (d_o !== prev) stable_ok = 1'b0;
            @(posedge clk_i);
            lat++;
            @(negedge clk_i);
        end
        res = {v_o, b_o, d_o};
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({busy_o, done_o, d_o, b_o, v_o} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs: got %b required 00000000", {busy_o, done_o, d_o, b_o, v_o});
        end
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({busy_o, done_o} !== 2'b00) begin
            failures++;
            $display("FAIL reset_idle: busy/done got %b required 00", {busy_o, done_o});
        end
    endtask

    task automatic check_op(input string name, input logic [3:0] x, input logic [3:0] y, input logic b);
        logic [5:0] res, exp;
        int lat;
        logic busy_ok, stable_ok;
        do_op(x, y, b, res, lat, busy_ok, stable_ok);
        exp = ref_sub(int'(x), int'(y), int'(b));
        checks++;
        if (lat != 4) begin
            failures++;
            $display("FAIL %s_latency: x=%0d y=%0d got %0d edges required 4", name, x, y, lat);
        end
        checks++;
        if (res !== exp) begin
            failures++;
            $display("FAIL %s_result: x=%0d y=%0d b=%0d got v,b,d=%b,%b,%0d required %b,%b,%0d",
                     name, x, y, b, res[5], res[4], res[3:0], exp[5], exp[4], exp[3:0]);
        end
        checks++;
        if (!busy_ok || !stable_ok) begin
            failures++;
            $display("FAIL %s_shift_phase: busy_ok=%b stable_ok=%b required 1,1", name, busy_ok, stable_ok);
        end
    endtask

    task automatic test_directed;
        check_op("basic", 4'd7, 4'd5, 1'b0);
        check_op("underflow", 4'd5, 4'd7, 1'b0);
        check_op("borrow_in", 4'd13, 4'd7, 1'b1);
        check_op("wrap_zero", 4'd0, 4'd0, 1'b1);
        check_op("ovf_pos", 4'd8, 4'd1, 1'b0);
        check_op("ovf_neg", 4'd7, 4'd8, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 30; i++)
            check_op("random", 4'($urandom), 4'($urandom), 1'($urandom));
    endtask

    task automatic test_start_mid_shift;
        logic [5:0] exp;
        logic [3:0] got_d;
        int pulses;
        exp = ref_sub(11, 4, 0);
        got_d = 4'hx;
        @(negedge clk_i);
        start_i = 1'b1; x_i = 4'd11; y_i = 4'd4; b_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b1; x_i = 4'd2; y_i = 4'd9; b_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (done_o === 1'b1) begin
                pulses++;
                got_d = d_o;
            end
            @(negedge clk_i);
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL mid_shift_pulses: got %0d done pulses required 1", pulses);
        end
        checks++;
        if (got_d !== exp[3:0]) begin
            failures++;
            $display("FAIL mid_shift_result: got %0d required %0d", got_d, exp[3:0]);
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] e1, e2;
        int edge_cnt, n_done;
        int done_edge[2];
        logic [3:0] done_d[2];
        e1 = ref_sub(7, 5, 0);
        e2 = ref_sub(13, 7, 0);
        done_edge[0] = -1; done_edge[1] = -1;
        done_d[0] = 4'hx; done_d[1] = 4'hx;
        @(negedge clk_i);
        start_i = 1'b1; x_i = 4'd7; y_i = 4'd5; b_i = 1'b0;
        @(posedge clk_i);
        edge_cnt = 0;
        n_done = 0;
        @(negedge clk_i);
        x_i = 4'd13; y_i = 4'd7;
        while (n_done < 2 && edge_cnt < 20) begin
            @(posedge clk_i);
            edge_cnt++;
            @(negedge clk_i);
            if (done_o === 1'b1) begin
                done_edge[n_done] = edge_cnt;
                done_d[n_done] = d_o;
                n_done++;
            end
            if (n_done == 2) start_i = 1'b0;
        end
        start_i = 1'b0;
        checks++;
        if (done_edge[0] != 4 || done_edge[1] != 9) begin
            failures++;
            $display("FAIL b2b_edges: got %0d,%0d required 4,9", done_edge[0], done_edge[1]);
        end
        checks++;
        if (done_d[0] !== e1[3:0] || done_d[1] !== e2[3:0]) begin
            failures++;
            $display("FAIL b2b_results: got %0d,%0d required %0d,%0d", done_d[0], done_d[1], e1[3:0], e2[3:0]);
        end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_reset_mid_op;
        int pulses;
        check_op("pre_reset", 4'd7, 4'd5, 1'b0);
        @(negedge clk_i);
        start_i = 1'b1; x_i = 4'd13; y_i = 4'd7; b_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, d_o, b_o, v_o} !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid_op_outputs: got %b required 00000000", {busy_o, done_o, d_o, b_o, v_o});
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            if (done_o !== 1'b0 || busy_o !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL reset_mid_op_quiet: got %0d active cycles required 0", pulses);
        end
        check_op("post_reset", 4'd9, 4'd3, 1'b0);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_start_mid_shift;
        test_back_to_back;
        test_reset_mid_op;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
